// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - memory-stage load/store unit with a valid/ready cache handshake
// Optional alignment trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_load,
  input  logic                req_store,
  input  logic [2:0]          req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                cache_req_valid,
  input  logic                cache_req_ready,
  output logic                cache_we,
  output logic [ADDR_W-1:0]   cache_addr,
  output logic [XLEN-1:0]     cache_wdata,
  output logic [XLEN/8-1:0]   cache_wstrb,
  input  logic                cache_resp_valid,
  input  logic [XLEN-1:0]     cache_resp_rdata,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [XLEN-1:0]     wb_data,
  output logic                wb_misaligned
);
  localparam int LANE_W = $clog2(XLEN/8);
  localparam int STRB_W = XLEN/8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          size_q, size_d;
  logic [LANE_W-1:0]   off_q, off_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [XLEN-1:0]     wb_data_q, wb_data_d;
  logic                mis_q, mis_d;

  logic                oversize;
  logic                misalign;
  logic [STRB_W-1:0]   strb_base;
  logic [XLEN-1:0]     rd_shifted, rd_mask, rd_top, rd_ext;
  logic                rd_sign;

  assign oversize = int'(req_size[1:0]) > LANE_W;

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (req_size[1:0])
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      default: misalign = |req_addr[2:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    strb_base = '0;
    case (req_size[1:0])
      2'd0:    strb_base = STRB_W'(8'h01);
      2'd1:    strb_base = STRB_W'(8'h03);
      2'd2:    strb_base = STRB_W'(8'h0F);
      default: strb_base = STRB_W'(8'hFF);
    endcase
  end

  // Load extraction: the mask's top bit locates the sign bit for any width.
  always_comb begin
    rd_shifted = cache_resp_rdata >> {off_q, 3'b000};
    rd_mask    = '1;
    case (size_q[1:0])
      2'd0:    rd_mask = XLEN'(8'hFF);
      2'd1:    rd_mask = XLEN'(16'hFFFF);
      2'd2:    rd_mask = XLEN'(32'hFFFF_FFFF);
      default: rd_mask = '1;
    endcase
    rd_top  = rd_mask & ~(rd_mask >> 1);
    rd_sign = |(rd_shifted & rd_top);
    rd_ext  = (rd_shifted & rd_mask) | ({XLEN{rd_sign & ~size_q[2]}} & ~rd_mask);
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    off_d     = off_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wb_data_d = wb_data_q;
    mis_d     = mis_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d      = req_store & ~req_load;
          size_d    = req_size;
          off_d     = req_addr[LANE_W-1:0];
          addr_d    = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
          wdata_d   = req_wdata << {req_addr[LANE_W-1:0], 3'b000};
          wstrb_d   = strb_base << req_addr[LANE_W-1:0];
          wb_data_d = '0;
          mis_d     = 1'b0;
          if (!(req_load || req_store)) begin
            state_d = S_DONE;
          end else if (oversize || misalign) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (cache_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cache_resp_valid) begin
          wb_data_d = we_q ? '0 : rd_ext;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      size_q    <= '0;
      off_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wb_data_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wb_data_q <= wb_data_d;
      mis_q     <= mis_d;
    end
  end

  // Request fields are only meaningful while cache_req_valid is high.
  assign req_ready       = (state_q == S_IDLE);
  assign cache_req_valid = (state_q == S_REQ);
  assign wb_valid        = (state_q == S_DONE);
  assign cache_we        = we_q;
  assign cache_addr      = addr_q;
  assign cache_wdata     = wdata_q;
  assign cache_wstrb     = wstrb_q;
  assign wb_data         = wb_data_q;
  assign wb_misaligned   = mis_q;
endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - self-checking bench for mem_stage_unit at XLEN=64 and XLEN=32
module tb_mem_stage_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid64, req_valid32;
  logic        req_load, req_store;
  logic [2:0]  req_size;
  logic [63:0] req_addr, req_wdata, resp_rdata;
  logic        cache_req_ready, cache_resp_valid, wb_ready;

  logic        a_rr, a_crv, a_we, a_wbv, a_mis;
  logic [63:0] a_addr, a_wdata, a_wbd;
  logic [7:0]  a_strb;
  logic        b_rr, b_crv, b_we, b_wbv, b_mis;
  logic [63:0] b_addr;
  logic [31:0] b_wdata, b_wbd;
  logic [3:0]  b_strb;

  logic        sel;
  logic        v_rr, v_crv, v_we, v_wbv, v_mis;
  logic [63:0] v_addr, v_wdata, v_wbd;
  logic [7:0]  v_strb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_unit #(.XLEN(64), .ADDR_W(64)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid64), .req_ready(a_rr),
    .req_load(req_load), .req_store(req_store), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .cache_req_valid(a_crv), .cache_req_ready(cache_req_ready),
    .cache_we(a_we), .cache_addr(a_addr), .cache_wdata(a_wdata), .cache_wstrb(a_strb),
    .cache_resp_valid(cache_resp_valid), .cache_resp_rdata(resp_rdata),
    .wb_valid(a_wbv), .wb_ready(wb_ready), .wb_data(a_wbd), .wb_misaligned(a_mis)
  );

  mem_stage_unit #(.XLEN(32), .ADDR_W(64)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid32), .req_ready(b_rr),
    .req_load(req_load), .req_store(req_store), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .cache_req_valid(b_crv), .cache_req_ready(cache_req_ready),
    .cache_we(b_we), .cache_addr(b_addr), .cache_wdata(b_wdata), .cache_wstrb(b_strb),
    .cache_resp_valid(cache_resp_valid), .cache_resp_rdata(resp_rdata[31:0]),
    .wb_valid(b_wbv), .wb_ready(wb_ready), .wb_data(b_wbd), .wb_misaligned(b_mis)
  );

  assign v_rr    = sel ? b_rr  : a_rr;
  assign v_crv   = sel ? b_crv : a_crv;
  assign v_we    = sel ? b_we  : a_we;
  assign v_wbv   = sel ? b_wbv : a_wbv;
  assign v_mis   = sel ? b_mis : a_mis;
  assign v_addr  = sel ? b_addr : a_addr;
  assign v_wdata = sel ? {32'h0, b_wdata} : a_wdata;
  assign v_wbd   = sel ? {32'h0, b_wbd} : a_wbd;
  assign v_strb  = sel ? {4'h0, b_strb} : a_strb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte arithmetic on the architectural meaning of each access.
  function automatic void model(input int xl, input bit ld, input bit st, input logic [2:0] sz,
                                input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                                output bit cache, output bit we, output logic [63:0] caddr,
                                output logic [63:0] cwd, output logic [7:0] strb,
                                output logic [63:0] wbd, output bit mis);
    int nb    = xl / 8;
    int off   = int'(addr % 64'(nb));
    int bytes = 1 << sz[1:0];
    logic [63:0] xmask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    logic [63:0] v, fmask;
    cache = 0; we = 0; mis = 0; wbd = 0; cwd = 0; strb = 0;
    caddr = addr - 64'(off);
    if (!ld && !st) return;
    if (bytes > nb) begin mis = 1; return; end
`ifdef MEM_MISALIGN_TRAP_EN
    if (addr % 64'(bytes) != 0) begin mis = 1; return; end
`endif
    cache = 1;
    we    = !ld;
    cwd   = ((wd & xmask) << (8 * off)) & xmask;
    strb  = 8'((((1 << bytes) - 1) << off) & ((1 << nb) - 1));
    if (ld) begin
      v = (rd & xmask) >> (8 * off);
      if (8 * bytes < 64) begin
        fmask = (64'd1 << (8 * bytes)) - 1;
        v = v & fmask;
        if (!sz[2] && v[8 * bytes - 1]) v = v | ~fmask;
      end
      wbd = v & xmask;
    end
  endfunction

  task automatic do_op(input bit s, input bit ld, input bit st, input logic [2:0] sz,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                       input int cstall, input int rdly, input int wstall);
    bit e_cache, e_we, e_mis;
    logic [63:0] e_caddr, e_cwd, e_wbd, xmask;
    logic [7:0] e_strb;
    xmask = s ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    model(s ? 32 : 64, ld, st, sz, addr, wd & xmask, rd & xmask,
          e_cache, e_we, e_caddr, e_cwd, e_strb, e_wbd, e_mis);
    sel = s;
    @(negedge clk);
    req_load = ld; req_store = st; req_size = sz; req_addr = addr; req_wdata = wd;
    if (s) req_valid32 = 1'b1; else req_valid64 = 1'b1;
    chk("req_ready_idle", v_rr, 1);
    @(negedge clk);
    req_valid32 = 1'b0; req_valid64 = 1'b0;
    req_wdata = {$urandom, $urandom};
    req_addr  = {$urandom, $urandom};
    if (e_cache) begin
      for (int k = 0; k <= cstall; k++) begin
        chk("cache_req_valid", v_crv, 1);
        chk("cache_we", v_we, e_we);
        chk("cache_addr", v_addr, e_caddr);
        chk("cache_wdata", v_wdata, e_cwd);
        chk("cache_wstrb", v_strb, e_strb);
        chk("req_ready_busy", v_rr, 0);
        chk("wb_valid_early", v_wbv, 0);
        cache_req_ready = (k == cstall);
        cache_resp_valid = 1'b1;
        @(negedge clk);
      end
      cache_req_ready = 1'b0;
      cache_resp_valid = 1'b0;
      for (int k = 0; k < rdly; k++) begin
        chk("wait_no_req", v_crv, 0);
        chk("wait_no_wb", v_wbv, 0);
        @(negedge clk);
      end
      cache_resp_valid = 1'b1;
      resp_rdata = rd;
      @(negedge clk);
      cache_resp_valid = 1'b0;
      resp_rdata = {$urandom, $urandom};
    end else begin
      chk("no_cache_req", v_crv, 0);
    end
    for (int k = 0; k <= wstall; k++) begin
      chk("wb_valid", v_wbv, 1);
      chk("wb_data", v_wbd, e_wbd);
      chk("wb_misaligned", v_mis, e_mis);
      chk("req_ready_done", v_rr, 0);
      chk("done_no_req", v_crv, 0);
      wb_ready = (k == wstall);
      @(negedge clk);
    end
    wb_ready = 1'b0;
    chk("wb_valid_after", v_wbv, 0);
    chk("req_ready_after", v_rr, 1);
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0;
    req_valid64 = 0; req_valid32 = 0; req_load = 0; req_store = 0; req_size = 0;
    req_addr = 0; req_wdata = 0; resp_rdata = 0;
    cache_req_ready = 0; cache_resp_valid = 0; wb_ready = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_req_ready", v_rr, 1);
      chk("rst_cache_req_valid", v_crv, 0);
      chk("rst_cache_we", v_we, 0);
      chk("rst_cache_addr", v_addr, 0);
      chk("rst_cache_wdata", v_wdata, 0);
      chk("rst_cache_wstrb", v_strb, 0);
      chk("rst_wb_valid", v_wbv, 0);
      chk("rst_wb_data", v_wbd, 0);
      chk("rst_wb_misaligned", v_mis, 0);
    end
    @(negedge clk);
    reset = 1'b1;

    do_op(0, 1, 0, 3'd0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0);
    do_op(0, 0, 1, 3'd2, 64'h2004, 64'h1234_5678, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 0);
    do_op(0, 1, 0, 3'd1, 64'h3001, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
    do_op(0, 1, 0, 3'd3, 64'h4000, 64'h0, 64'hFEDC_BA98_7654_3210, 5, 2, 3);
    do_op(0, 0, 0, 3'd2, 64'h5000, 64'h1, 64'h2, 0, 0, 1);
    do_op(0, 1, 1, 3'd2, 64'h6008, 64'h55, 64'h8000_0000_0000_0000, 0, 0, 0);
    do_op(1, 1, 0, 3'd4, 64'h7, 64'h0, 64'hAB00_0000, 0, 0, 0);
    do_op(1, 1, 0, 3'd3, 64'h8000, 64'h0, 64'h1, 0, 0, 0);
    do_op(1, 0, 1, 3'd1, 64'h9002, 64'hBEEF, 64'h0, 2, 1, 2);

    sel = 1'b0;
    @(negedge clk);
    req_load = 1; req_store = 0; req_size = 3'd2; req_addr = 64'hA000; req_valid64 = 1'b1;
    @(negedge clk);
    req_valid64 = 1'b0;
    chk("rw_req_valid", v_crv, 1);
    cache_req_ready = 1'b1;
    @(negedge clk);
    cache_req_ready = 1'b0;
    chk("rw_in_wait", v_crv, 0);
    reset = 1'b0;
    #1;
    chk("rw_rst_req_ready", v_rr, 1);
    chk("rw_rst_req_valid", v_crv, 0);
    chk("rw_rst_wb_valid", v_wbv, 0);
    chk("rw_rst_cache_addr", v_addr, 0);
    chk("rw_rst_wb_data", v_wbd, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cache_resp_valid = 1'b1; resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    cache_resp_valid = 1'b0;
    chk("rw_stray_wb_valid", v_wbv, 0);
    chk("rw_stray_req_valid", v_crv, 0);
    chk("rw_stray_req_ready", v_rr, 1);
    @(negedge clk);
    chk("rw_stray_wb_valid2", v_wbv, 0);

    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 3);
      do_op(i[0], op[0], op[1], 3'($urandom_range(0, 7)), {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_stage_unit.md
# mem_stage_unit

Parametrised memory-stage unit placed between the EX/MEM and MEM/WB pipeline registers. It accepts one load or store per handshake, issues a single request to the data cache, and waits for the cache response. It then returns size-aligned, sign- or zero-extended load data, or a store acknowledgement, to writeback. It generalises the existing single-width, enable-driven handler into a valid/ready FSM with byte lanes, write strobes and misalignment detection.

## Interface
- XLEN, default 64: data width; legal values are 32 and 64.
- ADDR_W, default 64: address width.
- LANE_W, derived, equal to log2(XLEN/8): number of byte-offset bits.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  **asynchronous, active-low** reset.
- req_valid / req_ready  in / out  1 / 1  request handshake from the EX/MEM stage.
- req_load, req_store  in  1 each  operation type.
- req_size  in  3  bits [1:0] give log2(bytes): 0=B, 1=H, 2=W, 3=D. Bit [2]=1 selects an unsigned load.
- req_addr  in  ADDR_W  effective address from the ALU.
- req_wdata  in  XLEN  store data, right-aligned.
- cache_req_valid / cache_req_ready  out / in  1 / 1  cache request handshake.
- cache_we  out  1  1 = store.
- cache_addr  out  ADDR_W  req_addr with the low LANE_W bits cleared.
- cache_wdata  out  XLEN  store data shifted to its byte lane.
- cache_wstrb  out  XLEN/8  byte-enable mask.
- cache_resp_valid  in  1  one-cycle pulse: read data is valid, or the write has completed.
- cache_resp_rdata  in  XLEN  aligned word.
- wb_valid / wb_ready  out / in  1 / 1  result handshake to MEM/WB.
- wb_data  out  XLEN  extended load data; 0 for stores and non-memory operations.
- wb_misaligned  out  1  exception flag, qualified by wb_valid.

## Operation
- The FSM has four states: IDLE, REQ, WAIT and DONE.
- **IDLE:** req_ready=1. On a request handshake, latch the request, then:
  - if the operation is neither a load nor a store, go to DONE.
  - if the access is misaligned (see Configuration), go to DONE.
  - if req_size[1:0] is greater than LANE_W, go to DONE with wb_misaligned=1.
  - otherwise go to REQ.
  - If req_load and req_store are both 1, treat the request as a load.
- **REQ:** cache_req_valid=1. Outputs stay stable until cache_req_ready=1, then go to WAIT.
- **WAIT:** stay until cache_resp_valid=1, then go to DONE.
  - On a load, capture the extracted and extended data.
  - On a store, wb_data=0.
- **DONE:** wb_valid=1. Stay until wb_ready=1, then go to IDLE.
- Load extraction: shift cache_resp_rdata right by 8·addr[LANE_W-1:0], keep 8·2^size bits, then:
  - sign-extend when req_size[2]=0;
  - zero-extend when req_size[2]=1.
- Store lanes:
  - cache_wdata = req_wdata shifted left by 8·offset.
  - cache_wstrb = ((1<<2^size)-1) shifted left by offset.
- cache_resp_valid is ignored in IDLE, REQ and DONE.

## Timing
- Reset values: every output is 0, except req_ready=1. State=IDLE and all latched request fields are cleared.
- Reset takes effect immediately at any state, including mid-REQ or mid-WAIT. Any in-flight request is abandoned; a response arriving after reset is dropped because the FSM is in IDLE.
- Minimum latency, with the request handshake at cycle 0:
  - cache_req_valid rises in cycle 1.
  - With cache_req_ready=1 in cycle 1 and cache_resp_valid=1 in cycle 2, wb_valid rises in cycle 3.
- Non-memory and misaligned requests: wb_valid rises in cycle 1 and no cache request is issued.
- req_ready=0 from cycle 1 until the cycle after the wb handshake. At most one operation is outstanding.
- All cache_* and wb_* outputs are registered.
- wb_data and wb_misaligned hold stable while wb_valid=1 and wb_ready=0.

## Configuration
- MEM_MISALIGN_TRAP_EN:
  - **Defined:** an access whose addr mod 2^size ≠ 0 skips the cache and completes with wb_misaligned=1 and wb_data=0.
  - **Undefined:** there is no alignment check and wb_misaligned is driven only by the oversize check. Bytes that fall outside the lane are truncated in both the strobe and the data.

## Test plan
- **Signed load:** XLEN=64, LD, size=0, addr=0x1003; cache returns 0x0000_0000_8000_0000 → cache_addr=0x1000, wb_data=0xFFFF_FFFF_FFFF_FF80, wb_valid in cycle 3.
- **Store:** SW with addr=0x2004, wdata=0x1234_5678 → cache_we=1, cache_wstrb=0xF0, cache_wdata=0x1234_5678_0000_0000, wb_data=0 after the response.
- **Misaligned access:** with MEM_MISALIGN_TRAP_EN defined, LH at addr=0x3001 → no cache_req_valid, wb_valid=1 and wb_misaligned=1 in cycle 1.
- **Backpressure:** cache_req_ready held 0 for 5 cycles, then wb_ready held 0 for 3 cycles → request and result outputs stay stable and req_ready stays 0 throughout.
- **Reset in WAIT:** assert reset in WAIT, then pulse cache_resp_valid after reset releases → outputs reach reset values immediately, the stray response is ignored, and wb_valid stays 0.
- **Unsigned load, narrow XLEN:** XLEN=32, LBU at addr=0x7 with rdata=0xAB00_0000 → wb_data=0x0000_00AB. A D-size request completes with wb_misaligned=1.
